// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Purpose:
//   Drives an LED bar with one of four patterns: OFF, ROTATE, BOUNCE or BLINK.
//   A mode change is requested with a valid/ready handshake. An accepted
//   non-OFF request passes through a one-cycle LOAD state, where the initial
//   pattern is loaded, and then runs. In RUN a step counter divides the clock
//   down to the pattern step rate. An accepted OFF request blanks the bar on
//   the accept edge.
//
// Configuration macro:
//   LED_SEQ_BRIGHTNESS_EN - when defined, a free-running 4-bit PWM counter
//   gates every LED with (pwm_cnt < brightness). brightness = 4'hF forces full
//   on. When the macro is undefined, brightness is ignored and no PWM logic is
//   built.
//
// Parameters:
//   CLK_FREQ  - input clock frequency in Hz
//   STEP_HZ   - pattern step rate in Hz (CLK_FREQ/STEP_HZ must be >= 2)
//   NUM_LEDS  - LED vector width (>= 2)
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   mode_req_valid in   mode change request valid
//   mode_req       in   requested mode (0 OFF, 1 ROTATE, 2 BOUNCE, 3 BLINK)
//   mode_req_ready out  request accepted on an edge where valid && ready
//   brightness     in   PWM duty code (only used with LED_SEQ_BRIGHTNESS_EN)
//   led            out  registered LED drive
//   mode           out  currently active mode
//   step_tick      out  one-cycle pulse on each pattern step
// -----------------------------------------------------------------------------
module led_sequencer #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned STEP_HZ  = 2,
  parameter int unsigned NUM_LEDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_req_valid,
  input  logic [1:0]          mode_req,
  output logic                mode_req_ready,
  input  logic [3:0]          brightness,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic                step_tick
);

  localparam logic [31:0] STEP_CYCLES = 32'(CLK_FREQ / STEP_HZ);
  localparam logic [31:0] STEP_LAST   = STEP_CYCLES - 32'd1;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  // dir = 1 means moving toward the MSB
  localparam logic DIR_UP = 1'b1;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [NUM_LEDS-1:0]  pat_q, pat_d;
  logic                 dir_q, dir_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 tick_q, tick_d;

  logic                 accept;
  logic                 wrap;

  // ---------------------------------------------------------------------------
  // Pattern helpers
  // ---------------------------------------------------------------------------
  function automatic logic [NUM_LEDS-1:0] init_pattern(input logic [1:0] m);
    logic [NUM_LEDS-1:0] p;
    p = '0;
    case (m)
      MODE_ROTATE,
      MODE_BOUNCE: p[0] = 1'b1;
      MODE_BLINK:  p    = '1;
      default:     p    = '0;
    endcase
    return p;
  endfunction

  function automatic logic [NUM_LEDS-1:0] rotate_left(input logic [NUM_LEDS-1:0] p);
    return {p[NUM_LEDS-2:0], p[NUM_LEDS-1]};
  endfunction

  // Returns {new_dir, new_pattern}. The direction flips when the lit bit sits
  // at an end, so the end bit is shown exactly once per sweep.
  function automatic logic [NUM_LEDS:0] bounce_step(input logic [NUM_LEDS-1:0] p,
                                                    input logic                d);
    logic [NUM_LEDS:0] r;
    if (d == DIR_UP) begin
      if (p[NUM_LEDS-1]) r = {1'b0, (p >> 1)};
      else               r = {1'b1, (p << 1)};
    end else begin
      if (p[0])          r = {1'b1, (p << 1)};
      else               r = {1'b0, (p >> 1)};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and step wrap detection
  // ---------------------------------------------------------------------------
  assign accept = mode_req_valid && mode_req_ready;
  assign wrap   = (state_q == S_RUN) && (cnt_q == STEP_LAST);

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (mode_req == MODE_OFF) ? S_OFF : S_LOAD;
    end else if (state_q == S_LOAD) begin
      state_d = S_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: mode, pattern, direction, step counter, tick.
  // An accepted request takes priority over a step wrap on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [NUM_LEDS:0] bnc;
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    cnt_d  = '0;
    tick_d = 1'b0;
    bnc    = bounce_step(pat_q, dir_q);

    if (accept) begin
      mode_d = mode_req;
      if (mode_req == MODE_OFF) begin
        pat_d = '0;
        dir_d = DIR_UP;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          pat_d = init_pattern(mode_q);
          dir_d = DIR_UP;
        end
        S_RUN: begin
          if (wrap) begin
            tick_d = 1'b1;
            case (mode_q)
              MODE_ROTATE: pat_d = rotate_left(pat_q);
              MODE_BOUNCE: begin
                dir_d = bnc[NUM_LEDS];
                pat_d = bnc[NUM_LEDS-1:0];
              end
              MODE_BLINK:  pat_d = ~pat_q;
              default:     pat_d = '0;
            endcase
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

`ifdef LED_SEQ_BRIGHTNESS_EN
  logic [3:0]          pwm_q, pwm_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                pwm_on;

  // brightness = 4'hF would otherwise be dark for one slot out of 16
  always_comb begin
    pwm_d  = pwm_q + 4'd1;
    pwm_on = (brightness == 4'hF) || (pwm_q < brightness);
    led_d  = pat_d & {NUM_LEDS{pwm_on}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
      led_q <= '0;
    end else begin
      pwm_q <= pwm_d;
      led_q <= led_d;
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      mode_q  <= MODE_OFF;
      pat_q   <= '0;
      dir_q   <= DIR_UP;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_req_ready = (state_q != S_LOAD);
    mode           = mode_q;
    step_tick      = tick_q;
`ifdef LED_SEQ_BRIGHTNESS_EN
    led            = led_q;
`else
    led            = pat_q;
`endif
  end

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
//
// Directed and random stimulus for led_sequencer (CLK_FREQ=8, STEP_HZ=2,
// NUM_LEDS=4 -> 4 cycles per step). The reference model predicts the outputs
// after every clock edge from the elapsed cycles since the pattern was loaded
// (step n = t / STEP_CYCLES, pattern computed from n), pushes them into a
// queue, and a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_sequencer;

  localparam int CLK_FREQ = 8;
  localparam int STEP_HZ  = 2;
  localparam int NUM_LEDS = 4;
  localparam int SC       = CLK_FREQ / STEP_HZ;

  logic                clk = 1'b0;
  logic                rst;
  logic                mode_req_valid;
  logic [1:0]          mode_req;
  logic                mode_req_ready;
  logic [3:0]          brightness;
  logic [NUM_LEDS-1:0] led;
  logic [1:0]          mode;
  logic                step_tick;

  always #5 clk = ~clk;

  led_sequencer #(
    .CLK_FREQ (CLK_FREQ),
    .STEP_HZ  (STEP_HZ),
    .NUM_LEDS (NUM_LEDS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mode_req_valid (mode_req_valid),
    .mode_req       (mode_req),
    .mode_req_ready (mode_req_ready),
    .brightness     (brightness),
    .led            (led),
    .mode           (mode),
    .step_tick      (step_tick)
  );

  typedef struct packed {
    logic [NUM_LEDS-1:0] led;
    logic [1:0]          mode;
    logic                tick;
    logic                ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: 0 = off, 1 = loading, 2 = running
  int                  m_state;
  int                  m_mode;
  int                  m_t;
  int                  m_pwm;
  logic [NUM_LEDS-1:0] m_pat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Pattern after n steps, from the visible sequences of each mode
  function automatic logic [NUM_LEDS-1:0] pattern_at(input int md, input int n);
    logic [NUM_LEDS-1:0] r;
    int p;
    r = '0;
    case (md)
      1: r[n % NUM_LEDS] = 1'b1;
      2: begin
        p = n % (2 * (NUM_LEDS - 1));
        if (p < NUM_LEDS) r[p] = 1'b1;
        else              r[2 * (NUM_LEDS - 1) - p] = 1'b1;
      end
      3: r = (n % 2 == 0) ? '1 : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic exp_t model_step(input logic r, input logic v,
                                      input logic [1:0] q, input logic [3:0] br);
    exp_t e;
    logic gate;
    logic tick;
    gate = (br == 4'hF) || (m_pwm < int'(br));
    tick = 1'b0;
    if (r) begin
      m_state = 0;
      m_mode  = 0;
      m_pat   = '0;
      m_pwm   = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 16;
      if (v && m_state != 1) begin
        if (q == 2'd0) begin
          m_state = 0;
          m_mode  = 0;
          m_pat   = '0;
        end else begin
          m_state = 1;
          m_mode  = int'(q);
        end
      end else if (m_state == 1) begin
        m_state = 2;
        m_t     = 0;
        m_pat   = pattern_at(m_mode, 0);
      end else if (m_state == 2) begin
        m_t++;
        m_pat = pattern_at(m_mode, m_t / SC);
        tick  = (m_t % SC == 0);
      end
    end
`ifdef LED_SEQ_BRIGHTNESS_EN
    e.led = r ? '0 : (m_pat & {NUM_LEDS{gate}});
`else
    e.led = m_pat;
`endif
    e.mode  = 2'(m_mode);
    e.tick  = tick;
    e.ready = (m_state != 1);
    return e;
  endfunction

  // One clock: apply inputs, let the edge happen, predict its outcome
  task automatic cyc(input logic r, input logic v, input logic [1:0] q);
    rst            = r;
    mode_req_valid = v;
    mode_req       = q;
    @(posedge clk);
    #1;
    exp_q.push_back(model_step(r, v, q, brightness));
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b0, 1'b0, 2'd0);
  endtask

  // Monitor: one prediction per edge, compared half a cycle later
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led",            32'(led),            32'(e.led));
      check("mode",           32'(mode),           32'(e.mode));
      check("step_tick",      32'(step_tick),      32'(e.tick));
      check("mode_req_ready", 32'(mode_req_ready), 32'(e.ready));
    end
  end

  initial begin
    rst            = 1'b1;
    mode_req_valid = 1'b0;
    mode_req       = 2'd0;
    brightness     = 4'hF;
    m_state        = 0;
    m_mode         = 0;
    m_t            = 0;
    m_pwm          = 0;
    m_pat          = '0;

    // Reset, then first cycle after release must be ready
    repeat (3) cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);

    // ROTATE through a full revolution
    cyc(1'b0, 1'b1, 2'd1);
    run(22);

    // BOUNCE for more than 8 steps
    cyc(1'b0, 1'b1, 2'd2);
    run(38);

    // BLINK request arriving exactly on a step wrap edge
    begin
      int k;
      k = 0;
      while (!(m_state == 2 && ((m_t + 1) % SC == 0)) && k < 2 * SC + 4) begin
        cyc(1'b0, 1'b0, 2'd0);
        k++;
      end
      check("wrap_edge_found", 32'(m_state == 2 && ((m_t + 1) % SC == 0)), 32'd1);
    end
    cyc(1'b0, 1'b1, 2'd3);
    run(14);

    // Second request held into LOAD is ignored
    cyc(1'b0, 1'b1, 2'd1);
    cyc(1'b0, 1'b1, 2'd2);
    run(10);

    // OFF during ROTATE
    run(3);
    cyc(1'b0, 1'b1, 2'd0);
    run(8);

    // Reset pulse mid-BOUNCE
    cyc(1'b0, 1'b1, 2'd2);
    run(9);
    cyc(1'b1, 1'b0, 2'd0);
    run(3);

    // Restart of the active mode
    cyc(1'b0, 1'b1, 2'd2);
    run(7);
    cyc(1'b0, 1'b1, 2'd2);
    run(8);

`ifdef LED_SEQ_BRIGHTNESS_EN
    brightness = 4'd4;
    cyc(1'b0, 1'b1, 2'd3);
    run(40);
    brightness = 4'hF;
    run(20);
`endif

    // Random traffic, including rare resets and requests during LOAD
    for (int i = 0; i < 500; i++) begin
      brightness = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
          2'($urandom_range(0, 3)));
    end

    // Drain the scoreboard, bounded
    begin
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < 10) begin
        @(negedge clk);
        #1;
        k++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter STEP_HZ, default 2, pattern step rate in Hz; STEP_CYCLES = CLK_FREQ/STEP_HZ, must be >= 2.
REQ-003 SHALL have parameter NUM_LEDS, default 4, LED vector width, must be >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mode_req_valid  input  1  mode change request valid.
REQ-007 SHALL have port mode_req  input  2  requested mode: 0 OFF, 1 ROTATE, 2 BOUNCE, 3 BLINK.
REQ-008 SHALL have port mode_req_ready  output  1  request accepted on an edge where valid && ready.
REQ-009 SHALL have port brightness  input  4  PWM duty code; used only with the configuration macro.
REQ-010 SHALL have port led  output  NUM_LEDS  LED drive, registered.
REQ-011 SHALL have port mode  output  2  currently active mode.
REQ-012 SHALL have port step_tick  output  1  one-cycle pulse on each pattern step.

Function
REQ-013 SHALL implement FSM states S_OFF, S_LOAD, S_RUN; mode_req_ready = 1 in S_OFF and S_RUN, 0 in S_LOAD.
REQ-014 SHALL, on accepting mode_req = 0 from any state: next state S_OFF, led = 0, mode = 0, step counter = 0, all on the accept edge.
REQ-015 SHALL, on accepting mode_req != 0 on edge k: latch the mode into mode at edge k, enter S_LOAD; at edge k+1 load the initial pattern, clear the step counter, enter S_RUN. The pattern is visible 2 edges after acceptance.
REQ-016 SHALL hold led unchanged during S_LOAD.
REQ-017 SHALL set initial patterns as: ROTATE and BOUNCE = bit0 only set with direction = up; BLINK = all ones.
REQ-018 SHALL, in S_RUN, count the 32-bit step counter 0..STEP_CYCLES-1, then wrap to 0. On the wrap edge it SHALL advance the pattern and assert step_tick for exactly that following cycle.
REQ-019 SHALL step ROTATE as rotate-left by 1: MSB wraps into bit0 (4 LEDs: 0001,0010,0100,1000,0001).
REQ-020 SHALL step BOUNCE as a shift in the current direction, reversing on reaching bit NUM_LEDS-1 or bit0 (4 LEDs: 0001,0010,0100,1000,0100,0010,0001,0010).
REQ-021 SHALL step BLINK as bitwise invert (1111,0000,1111).
REQ-022 SHALL hold the step counter at 0 in S_OFF and S_LOAD, with no step_tick.
REQ-023 SHALL give an accepted request priority on the same edge as a step wrap: no pattern advance, step_tick stays 0.
REQ-024 SHALL treat a request for the already-active mode as a restart (S_LOAD, pattern reload).
REQ-025 SHALL NOT accept requests while mode_req_ready = 0; valid is simply ignored, not queued.

Reset
REQ-026 SHALL, while rst = 1 at a clock edge, set state = S_OFF, led = 0, mode = 0, step_tick = 0, step counter = 0, direction = up, PWM counter = 0.
REQ-027 SHALL give rst priority over any request; asserted mid-run, it aborts the pattern within one edge.
REQ-028 SHALL have mode_req_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL use macro LED_SEQ_BRIGHTNESS_EN, which when defined adds a free-running 4-bit PWM counter.
REQ-030 SHALL, with LED_SEQ_BRIGHTNESS_EN defined, drive led = pattern AND (pwm_cnt < brightness) for every bit, and force led = pattern when brightness = 4'hF.
REQ-031 SHALL, with LED_SEQ_BRIGHTNESS_EN undefined, drive led = pattern, ignore brightness, and contain no PWM logic.

Verification (CLK_FREQ=8, STEP_HZ=2 -> STEP_CYCLES=4, NUM_LEDS=4)
REQ-032 SHALL check: reset, then request ROTATE -> ready low 1 cycle, led=0001 two edges after accept, then 0010,0100,1000,0001 every 4 cycles with step_tick pulses.
REQ-033 SHALL check: BOUNCE for 8 steps -> led sequence 0010,0100,1000,0100,0010,0001,0010,0100.
REQ-034 SHALL check: BLINK request landing on a wrap edge -> no step_tick that cycle, led reloads 1111, then toggles every 4 cycles.
REQ-035 SHALL check: OFF request during ROTATE -> led=0000, mode=0 on accept edge, no further step_tick.
REQ-036 SHALL check: rst pulse mid-BOUNCE -> all outputs 0 next edge, ready=1 after release.
REQ-037 SHALL check: with LED_SEQ_BRIGHTNESS_EN, brightness=4, BLINK high phase -> each LED high 4 of every 16 cycles; brightness=15 -> always high.
